// File: rtl/dbg_run_ctrl.sv
// Debounced run/step/breakpoint sequencer and browse-address control for the CPU debug unit.
// Optional macro DBG_AUTO_REPEAT_EN adds press-and-hold auto-repeat on the inc/dec buttons.
module dbg_run_ctrl #(
  parameter logic [15:0] DB_CYCLES  = 16'd50000,
  parameter logic [23:0] RPT_DELAY  = 24'd5000000,
  parameter logic [23:0] RPT_PERIOD = 24'd1000000
) (
  input  logic        clk_out1,
  input  logic        rst,
  input  logic        count,
  input  logic        step,
  input  logic        inc,
  input  logic        dec,
  input  logic        brk_set,
  input  logic [31:0] pc,
  output logic        cpu_en,
  output logic        halted,
  output logic        brk_armed,
  output logic [7:0]  addr,
  output logic [7:0]  bp_addr,
  output logic [15:0] step_cnt
);

  typedef enum logic [2:0] {IDLE, STEP_PULSE, STEP_WAIT, RUN, BRK_HALT} state_t;

  localparam int N_IN    = 5;
  localparam int I_COUNT = 0;
  localparam int I_STEP  = 1;
  localparam int I_INC   = 2;
  localparam int I_DEC   = 3;
  localparam int I_BRK   = 4;

  logic [N_IN-1:0] raw, sync1, sync2, db, db_prev, rise;
  logic [15:0]     db_cnt [N_IN];
  state_t          state;
  logic            skip, match, disarm;
  logic            addr_up, addr_dn;
  logic [7:0]      pc_word;
  logic            unused_bits;

  assign raw     = {brk_set, dec, inc, step, count};
  assign rise    = db & ~db_prev;
  assign pc_word = pc[9:2];

  // A level only moves after the synced input has disagreed with it for DB_CYCLES cycles in a row.
  always_ff @(posedge clk_out1) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db      <= '0;
      db_prev <= '0;
      for (int i = 0; i < N_IN; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_CYCLES - 16'd1) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign match  = brk_armed & ~skip & (pc_word == bp_addr);
  assign disarm = rise[I_BRK] & brk_armed & (bp_addr == addr);
  assign halted = (state == BRK_HALT);

  // The enable drops in the very cycle the breakpoint PC appears, so the CPU never clocks it.
  always_comb begin
    cpu_en = 1'b0;
    if (!rst) begin
      case (state)
        STEP_PULSE: cpu_en = 1'b1;
        RUN:        cpu_en = ~match;
        default:    cpu_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      state <= IDLE;
      skip  <= 1'b0;
    end else begin
      case (state)
        IDLE:       if (db[I_COUNT]) state <= RUN;
                    else if (rise[I_STEP]) state <= STEP_PULSE;
        STEP_PULSE: state <= STEP_WAIT;
        STEP_WAIT:  if (!db[I_STEP]) state <= IDLE;
        RUN:        if (!db[I_COUNT]) state <= IDLE;
                    else if (match) state <= BRK_HALT;
        BRK_HALT:   if (disarm) state <= db[I_COUNT] ? RUN : IDLE;
                    else if (rise[I_STEP]) state <= STEP_PULSE;
                    else if (!db[I_COUNT]) state <= IDLE;
        default:    state <= IDLE;
      endcase
      // Skip lets a multicycle instruction at the breakpoint PC finish after a resume.
      if (rise[I_BRK]) skip <= 1'b0;
      else if (state == BRK_HALT && (rise[I_STEP] || !db[I_COUNT])) skip <= 1'b1;
      else if (pc_word != bp_addr) skip <= 1'b0;
    end
  end

`ifdef DBG_AUTO_REPEAT_EN
  logic [23:0] rpt_cnt [2];
  logic [1:0]  rpt_hold, rpt_started, rpt_fire;

  assign rpt_hold = {db[I_DEC] & ~db[I_INC], db[I_INC] & ~db[I_DEC]};

  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 2; i++)
      rpt_fire[i] = rpt_hold[i] &
                    (rpt_started[i] ? (rpt_cnt[i] == RPT_PERIOD) : (rpt_cnt[i] == RPT_DELAY));
  end

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      rpt_started <= '0;
      for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!rpt_hold[i]) begin
          rpt_cnt[i]     <= '0;
          rpt_started[i] <= 1'b0;
        end else if (rpt_fire[i]) begin
          rpt_cnt[i]     <= 24'd1;
          rpt_started[i] <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 24'd1;
        end
      end
    end
  end

  assign addr_up     = rise[I_INC] | rpt_fire[0];
  assign addr_dn     = rise[I_DEC] | rpt_fire[1];
  assign unused_bits = ^{pc[31:10], pc[1:0]};
`else
  assign addr_up     = rise[I_INC];
  assign addr_dn     = rise[I_DEC];
  assign unused_bits = ^{pc[31:10], pc[1:0], RPT_DELAY, RPT_PERIOD};
`endif

  always_ff @(posedge clk_out1) begin
    if (rst) begin
      brk_armed <= 1'b0;
      bp_addr   <= '0;
      addr      <= '0;
      step_cnt  <= '0;
    end else begin
      if (rise[I_BRK]) begin
        if (disarm) begin
          brk_armed <= 1'b0;
        end else begin
          bp_addr   <= addr;
          brk_armed <= 1'b1;
        end
      end
      if (addr_up && !addr_dn) addr <= addr + 8'd1;
      else if (addr_dn && !addr_up) addr <= addr - 8'd1;
      if (cpu_en && step_cnt != 16'hFFFF) step_cnt <= step_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Testbench for dbg_run_ctrl: a vector table for browse/breakpoint control, hand sequences for
// step/run/halt/reset, and randomized presses checked against a rule-level model.
module tb_dbg_run_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int OP_INC  = 0;
  localparam int OP_DEC  = 1;
  localparam int OP_BOTH = 2;
  localparam int OP_STEP = 3;
  localparam int OP_BRK  = 4;

  logic        clk_out1 = 1'b0;
  logic        rst, count, step, inc, dec, brk_set;
  logic [31:0] pc;
  logic        cpu_en, halted, brk_armed;
  logic [7:0]  addr, bp_addr;
  logic [15:0] step_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int en_total = 0;
  int en_at_bp = 0;
  int sub      = 0;

  typedef struct {
    int         op;
    logic [7:0] exp_addr;
    logic       exp_armed;
    logic [7:0] exp_bp;
  } vec_t;

  vec_t vecs [7];

  dbg_run_ctrl #(
    .DB_CYCLES (16'd4),
    .RPT_DELAY (24'd20),
    .RPT_PERIOD(24'd5)
  ) dut (
    .clk_out1 (clk_out1),
    .rst      (rst),
    .count    (count),
    .step     (step),
    .inc      (inc),
    .dec      (dec),
    .brk_set  (brk_set),
    .pc       (pc),
    .cpu_en   (cpu_en),
    .halted   (halted),
    .brk_armed(brk_armed),
    .addr     (addr),
    .bp_addr  (bp_addr),
    .step_cnt (step_cnt)
  );

  always #5 clk_out1 = ~clk_out1;

  // One clock: the CPU model executes on the edge if the enable was high during the cycle.
  // Its program runs 0x00..0x18 with 3 cycles per instruction, then loops 0x18 -> 0x0C.
  task automatic tick();
    logic en_s;
    @(negedge clk_out1);
    en_s = cpu_en;
    @(posedge clk_out1);
    #1;
    if (en_s) begin
      pulses++;
      en_total++;
      if (pc == 32'h0C) en_at_bp++;
      sub++;
      if (sub == 3) begin
        sub = 0;
        pc  = (pc == 32'h18) ? 32'h0C : pc + 32'd4;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply_stimulus(input int op, input int hold);
    pulses  = 0;
    inc     = (op == OP_INC) || (op == OP_BOTH);
    dec     = (op == OP_DEC) || (op == OP_BOTH);
    step    = (op == OP_STEP);
    brk_set = (op == OP_BRK);
    repeat (hold) tick();
    inc = 1'b0; dec = 1'b0; step = 1'b0; brk_set = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, first, exp_addr, exp_cnt, op, hold, exp_pulses, fires;

    vecs[0] = '{OP_DEC,  8'hFF, 1'b0, 8'h00};
    vecs[1] = '{OP_INC,  8'h00, 1'b0, 8'h00};
    vecs[2] = '{OP_BOTH, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{OP_INC,  8'h01, 1'b0, 8'h00};
    vecs[4] = '{OP_INC,  8'h02, 1'b0, 8'h00};
    vecs[5] = '{OP_INC,  8'h03, 1'b0, 8'h00};
    vecs[6] = '{OP_BRK,  8'h03, 1'b1, 8'h03};

    rst = 1'b1; count = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; brk_set = 1'b0; pc = '0;
    repeat (3) tick();
    check_output("reset cpu_en", cpu_en, 0);
    check_output("reset halted", halted, 0);
    check_output("reset brk_armed", brk_armed, 0);
    check_output("reset addr", addr, 0);
    check_output("reset bp_addr", bp_addr, 0);
    check_output("reset step_cnt", step_cnt, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Glitch shorter than the debounce window
    apply_stimulus(OP_STEP, 2);
    check_output("glitch pulses", pulses, 0);
    check_output("glitch step_cnt", step_cnt, 0);
    check_output("glitch halted", halted, 0);

    // Long step press gives exactly one pulse
    pulses = 0; first = 0; step = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (pulses == 1 && first == 0) first = i;
    end
    step = 1'b0;
    repeat (12) tick();
    check_output("step held pulses", pulses, 1);
    check_output("step latency in 6..9", (first >= 6 && first <= 9), 1);
    check_output("step_cnt after step", step_cnt, 1);
    apply_stimulus(OP_STEP, 10);
    check_output("re-press pulses", pulses, 1);
    check_output("step_cnt after re-press", step_cnt, 2);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].op, 10);
      check_output($sformatf("vec%0d addr", i), addr, vecs[i].exp_addr);
      check_output($sformatf("vec%0d brk_armed", i), brk_armed, vecs[i].exp_armed);
      check_output($sformatf("vec%0d bp_addr", i), bp_addr, vecs[i].exp_bp);
    end

    // Run into the breakpoint at word 3 (pc 0x0C)
    pc = '0; sub = 0; en_at_bp = 0; pulses = 0; count = 1'b1;
    n = 0;
    while (!halted && n < 100) begin tick(); n++; end
    check_output("first halt reached", halted, 1);
    check_output("halt pc", pc, 32'h0C);
    check_output("cycles before halt", pulses, 9);
    check_output("enabled cycles at bp pc", en_at_bp, 0);
    check_output("cpu_en while halted", cpu_en, 0);

    // Resume by one step with count still on; must run past 0x0C and halt on the loop back
    en_at_bp = 0; pulses = 0; step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    repeat (5) tick();
    check_output("resume step pulses", pulses, 1);
    check_output("not halted after resume", halted, 0);
    n = 0;
    while (!halted && n < 200) begin tick(); n++; end
    check_output("second halt reached", halted, 1);
    check_output("cycles until second halt", pulses, 12);
    check_output("cycles spent at bp pc", en_at_bp, 3);
    check_output("second halt pc", pc, 32'h0C);

    // Disarm while halted resumes running
    apply_stimulus(OP_BRK, 10);
    check_output("disarm brk_armed", brk_armed, 0);
    check_output("disarm halted", halted, 0);
    check_output("running after disarm", (pulses > 0), 1);
    count = 1'b0;
    repeat (12) tick();
    pulses = 0;
    repeat (5) tick();
    check_output("idle after count off", pulses, 0);

    // Reset in the middle of a run at step_cnt = 37
    rst = 1'b1; tick(); rst = 1'b0; en_total = 0;
    apply_stimulus(OP_DEC, 10);
    apply_stimulus(OP_BRK, 10);
    check_output("pre-reset brk_armed", brk_armed, 1);
    check_output("pre-reset bp_addr", bp_addr, 8'hFF);
    pc = '0; sub = 0; count = 1'b1;
    n = 0;
    while (en_total < 37 && n < 200) begin tick(); n++; end
    check_output("reached 37 enabled cycles", en_total, 37);
    check_output("step_cnt before reset", step_cnt, 37);
    rst = 1'b1;
    #1;
    check_output("cpu_en gated by rst", cpu_en, 0);
    tick();
    check_output("mid-run reset step_cnt", step_cnt, 0);
    check_output("mid-run reset addr", addr, 0);
    check_output("mid-run reset brk_armed", brk_armed, 0);
    check_output("mid-run reset bp_addr", bp_addr, 0);
    check_output("mid-run reset halted", halted, 0);
    rst = 1'b0; count = 1'b0; en_total = 0;
    #1;
    check_output("cpu_en after reset", cpu_en, 0);

    // Random presses against the rule model
    exp_addr = 0; exp_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      op   = int'($urandom_range(0, 3));
      hold = (op == OP_STEP) ? int'($urandom_range(1, 8)) : 10;
      apply_stimulus(op, hold);
      if (op == OP_INC) exp_addr = (exp_addr + 1) % 256;
      if (op == OP_DEC) exp_addr = (exp_addr + 255) % 256;
      check_output($sformatf("rand%0d addr", k), addr, exp_addr);
      if (op == OP_STEP) begin
        exp_pulses = (hold >= DB) ? 1 : 0;
        exp_cnt    = exp_cnt + exp_pulses;
        check_output($sformatf("rand%0d step pulses (hold %0d)", k, hold), pulses, exp_pulses);
        check_output($sformatf("rand%0d step_cnt", k), step_cnt, exp_cnt);
      end
    end

    // Long inc hold: one step per press, plus repeats when auto-repeat is built in
    apply_stimulus(OP_INC, 60);
`ifdef DBG_AUTO_REPEAT_EN
    fires = (60 > RD) ? (60 - 1 - RD) / RP + 1 : 0;
`else
    fires = 0;
`endif
    exp_addr = (exp_addr + 1 + fires) % 256;
    check_output("long inc hold addr", addr, exp_addr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
